// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus bundle: adder hookup, instruction-memory port, redirect and IF/ID handoff.
interface fetch_pc_ctrl_if #(
    parameter int unsigned WORD    = 64,
    parameter int unsigned INSTR_W = 32
);
    logic [WORD-1:0]    pc_to_adder;
    logic [WORD-1:0]    adder_sum;
    logic               imem_req;
    logic [WORD-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               branch_taken;
    logic [WORD-1:0]    branch_target;
    logic               id_ready;
    logic               ifid_valid;
    logic [WORD-1:0]    ifid_pc;
    logic [INSTR_W-1:0] ifid_instr;

    // Controller side.
    modport master (
        output pc_to_adder,
        input  adder_sum,
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata,
        input  branch_taken,
        input  branch_target,
        input  id_ready,
        output ifid_valid,
        output ifid_pc,
        output ifid_instr
    );

    // Environment side: adder, instruction memory, later stages and decode.
    modport slave (
        input  pc_to_adder,
        output adder_sum,
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata,
        output branch_taken,
        output branch_target,
        output id_ready,
        input  ifid_valid,
        input  ifid_pc,
        input  ifid_instr
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: sequences instruction-memory reads, buffers one instruction under
// decode back-pressure, and fills the IF/ID register. Next sequential PC comes from the
// external adder (PC+4); taken-branch redirects flush everything in flight.
module fetch_pc_ctrl #(
    parameter int unsigned    WORD     = 64,
    parameter int unsigned    INSTR_W  = 32,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              reset,
    fetch_pc_ctrl_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StWaitId} state_t;

    state_t             r_state;
    logic [WORD-1:0]    r_pc;
    logic [INSTR_W-1:0] r_pend_instr;
    logic               r_ifid_valid;
    logic [WORD-1:0]    r_ifid_pc;
    logic [INSTR_W-1:0] r_ifid_instr;

    logic               w_slot_free;
    logic [WORD-1:0]    w_redirect_pc;

    assign w_slot_free   = !r_ifid_valid || bus.id_ready;
    // Targets are word aligned; low address bits from the branch unit are ignored.
    assign w_redirect_pc = {bus.branch_target[WORD-1:2], 2'b00};

    // PC, fetch FSM, pending buffer and IF/ID register update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_pend_instr <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
        end else begin
            // Decode consumed the entry; a reload below overrides this.
            if (r_ifid_valid && bus.id_ready) begin
                r_ifid_valid <= 1'b0;
            end

            if (bus.branch_taken) begin
                r_pc         <= w_redirect_pc;
                r_ifid_valid <= 1'b0;
                r_pend_instr <= '0;
                r_state      <= StFetch;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_state <= StFetch;
                    end
                    StFetch: begin
                        if (bus.imem_valid) begin
                            if (w_slot_free) begin
                                r_ifid_valid <= 1'b1;
                                r_ifid_pc    <= r_pc;
                                r_ifid_instr <= bus.imem_rdata;
                                r_pc         <= bus.adder_sum;
                            end else begin
                                // Hold PC: it stays the address of the buffered word.
                                r_pend_instr <= bus.imem_rdata;
                                r_state      <= StWaitId;
                            end
                        end
                    end
                    StWaitId: begin
                        if (bus.id_ready) begin
                            r_ifid_valid <= 1'b1;
                            r_ifid_pc    <= r_pc;
                            r_ifid_instr <= r_pend_instr;
                            r_pc         <= bus.adder_sum;
                            r_state      <= StFetch;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.pc_to_adder = r_pc;
    assign bus.imem_addr   = r_pc;
    assign bus.imem_req    = (r_state == StFetch) && !bus.branch_taken;
    assign bus.ifid_valid  = r_ifid_valid;
    assign bus.ifid_pc     = r_ifid_pc;
    assign bus.ifid_instr  = r_ifid_instr;

endmodule
